// File: rtl/rr_sel_arbiter8.sv
// rr_sel_arbiter8
//   Eight-channel round-robin arbiter that drives the 3-bit select of the
//   8-to-1 multibit output mux directly downstream. One requesting channel is
//   granted at a time. The select is held for up to BURST_MAX accepted beats,
//   and then priority rotates to the channel after the one just served.
//
//   State table:
//     state | meaning
//     IDLE  | no owner; gnt=0; ctrl holds its last value; arbitrate on req
//     GRANT | channel ctrl owns the mux; count accepted beats until release
//
// Ports:
//   clk        in   1  system clock, rising edge
//   rst_n      in   1  asynchronous active-low reset
//   req        in   8  per-channel request (bit i = channel i has a beat)
//   out_ready  in   1  downstream accepts a beat this cycle
//   ctrl       out  3  mux select, registered
//   gnt        out  8  one-hot grant, registered, zero while idle
//   out_valid  out  1  selected channel's beat is valid on the mux output
module rr_sel_arbiter8 #(
    parameter int BURST_MAX = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] req,
    input  logic       out_ready,
    output logic [2:0] ctrl,
    output logic [7:0] gnt,
    output logic       out_valid
);

    localparam int CNT_W = $clog2(BURST_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BURST_MAX - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t           state, state_nxt;
    logic [2:0]       ptr, ptr_nxt;
    logic [2:0]       ctrl_nxt;
    logic [7:0]       gnt_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;

    // Rotated request vector: bit k is the request of channel ptr+k (mod 8).
    // The lowest set bit is therefore the first channel found when the search
    // starts at the pointer.
    logic [15:0] req_dbl;
    logic [7:0]  req_rot;
    logic [2:0]  pick_off;
    logic [2:0]  pick_idx;

    assign req_dbl = {req, req};
    assign req_rot = req_dbl[ptr +: 8];

    always_comb begin
        pick_off = 3'd0;
        // Walk from the top down so the lowest set offset is the one kept.
        for (int k = 7; k >= 0; k--) begin
            if (req_rot[k]) begin
                pick_off = 3'(k);
            end
        end
    end

    assign pick_idx = ptr + pick_off;

    logic sel_req;
    logic xfer;
    logic burst_done;

    assign sel_req    = req[ctrl];
    // out_valid uses the registered ctrl, so it can only change when the
    // owner's own request changes; no glitch from the other channels.
    assign out_valid  = (state == GRANT) && sel_req;
    assign xfer       = out_valid && out_ready;
    assign burst_done = xfer && (cnt == CNT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            ptr   <= 3'd0;
            ctrl  <= 3'd0;
            gnt   <= 8'h00;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            ptr   <= ptr_nxt;
            ctrl  <= ctrl_nxt;
            gnt   <= gnt_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        ctrl_nxt  = ctrl;
        gnt_nxt   = gnt;
        cnt_nxt   = cnt;

        unique case (state)
            IDLE: begin
                gnt_nxt = 8'h00;
                if (req != 8'h00) begin
                    state_nxt = GRANT;
                    ctrl_nxt  = pick_idx;
                    gnt_nxt   = 8'h01 << pick_idx;
                    cnt_nxt   = '0;
                end
            end

            GRANT: begin
                // A dropped request releases without counting a beat; a full
                // burst releases on its last accepted beat. Either way the
                // pointer moves past the channel just served.
                if (!sel_req || burst_done) begin
                    state_nxt = IDLE;
                    gnt_nxt   = 8'h00;
                    ptr_nxt   = ctrl + 3'd1;
                    cnt_nxt   = '0;
                end else if (xfer) begin
                    cnt_nxt = cnt + CNT_ONE;
                end
            end

            default: begin
                state_nxt = IDLE;
                gnt_nxt   = 8'h00;
                cnt_nxt   = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_rr_sel_arbiter8.sv
// Bench for rr_sel_arbiter8: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a behavioural model
// that tracks "current owner / beats left / next start channel".
module tb_rr_sel_arbiter8;

    localparam int BURST_MAX = 4;

    logic       clk;
    logic       rst_n;
    logic [7:0] req;
    logic       out_ready;
    logic [2:0] ctrl;
    logic [7:0] gnt;
    logic       out_valid;

    int n_checks = 0;
    int n_fail   = 0;

    rr_sel_arbiter8 #(.BURST_MAX(BURST_MAX)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .out_ready (out_ready),
        .ctrl      (ctrl),
        .gnt       (gnt),
        .out_valid (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int m_owner = -1;   // granted channel, -1 when idle
    int m_last  = 0;    // last channel granted (mux select value)
    int m_left  = 0;    // beats still allowed in this burst
    int m_next  = 0;    // channel where the next search starts

    always @(negedge rst_n) begin
        m_owner = -1;
        m_last  = 0;
        m_left  = 0;
        m_next  = 0;
    end

    always @(posedge clk) begin
        if (rst_n) begin
            if (m_owner < 0) begin
                for (int k = 0; k < 8; k++) begin
                    int c;
                    c = (m_next + k) % 8;
                    if (m_owner < 0 && req[c]) begin
                        m_owner = c;
                        m_last  = c;
                        m_left  = BURST_MAX;
                    end
                end
            end else if (!req[m_owner]) begin
                m_next  = (m_owner + 1) % 8;
                m_owner = -1;
            end else if (out_ready) begin
                m_left = m_left - 1;
                if (m_left == 0) begin
                    m_next  = (m_owner + 1) % 8;
                    m_owner = -1;
                end
            end
        end
    end

    // Compare every cycle, 1 time unit after the active edge.
    always @(posedge clk) begin
        #1;
        chk("model_gnt",   32'(gnt), (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0);
        chk("model_ctrl",  32'(ctrl), 32'(m_last));
        chk("model_valid", 32'(out_valid), (m_owner >= 0 && req[m_owner]) ? 32'd1 : 32'd0);
    end

    task automatic wait_gnt(input string name, input logic [7:0] exp, input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (gnt == exp) break;
        end
        chk(name, 32'(gnt), 32'(exp));
    endtask

    initial begin
        int accepted;

        rst_n     = 1'b0;
        req       = 8'h00;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_ctrl",  32'(ctrl), 32'd0);
        chk("reset_gnt",   32'(gnt), 32'h00);
        chk("reset_valid", 32'(out_valid), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_gnt", 32'(gnt), 32'h00);

        // Sole requester: 4-beat burst, one bubble, re-granted.
        req       = 8'h20;
        out_ready = 1'b1;
        @(negedge clk);
        chk("single_gnt",  32'(gnt), 32'h20);
        chk("single_ctrl", 32'(ctrl), 32'd5);
        chk("single_ov",   32'(out_valid), 32'd1);
        for (int b = 1; b < 4; b++) begin
            @(negedge clk);
            chk("single_hold_gnt", 32'(gnt), 32'h20);
            chk("single_hold_ov",  32'(out_valid), 32'd1);
        end
        @(negedge clk);
        chk("single_bubble_gnt",  32'(gnt), 32'h00);
        chk("single_bubble_ov",   32'(out_valid), 32'd0);
        chk("single_bubble_ctrl", 32'(ctrl), 32'd5);
        @(negedge clk);
        chk("single_regrant", 32'(gnt), 32'h20);

        // Reset asserted mid-burst on channel 3.
        req = 8'h00;
        wait_gnt("drop_to_idle", 8'h00, 4);
        req = 8'h08;
        wait_gnt("ch3_gnt", 8'h08, 4);
        chk("ch3_ctrl", 32'(ctrl), 32'd3);
        #3 rst_n = 1'b0;
        #1;
        chk("midrst_ctrl",  32'(ctrl), 32'd0);
        chk("midrst_gnt",   32'(gnt), 32'h00);
        chk("midrst_valid", 32'(out_valid), 32'd0);
        req = 8'h0A;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("after_rst_gnt",  32'(gnt), 32'h02);
        chk("after_rst_ctrl", 32'(ctrl), 32'd1);

        // Pointer wrap: burst on 7, then 0 is next ahead of 7.
        req = 8'h00;
        wait_gnt("wrap_idle", 8'h00, 4);
        req = 8'h80;
        wait_gnt("wrap_ch7", 8'h80, 4);
        req = 8'h81;
        wait_gnt("wrap_release", 8'h00, 8);
        @(negedge clk);
        chk("wrap_gnt",  32'(gnt), 32'h01);
        chk("wrap_ctrl", 32'(ctrl), 32'd0);

        // Back-pressure on channel 2.
        req = 8'h00;
        wait_gnt("bp_idle", 8'h00, 4);
        req = 8'h04;
        wait_gnt("bp_gnt", 8'h04, 4);
        accepted = 1;
        @(negedge clk);
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("bp_ctrl", 32'(ctrl), 32'd2);
            chk("bp_ov",   32'(out_valid), 32'd1);
            @(negedge clk);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 20 && gnt == 8'h04; i++) begin
            if (out_valid && out_ready) accepted++;
            @(negedge clk);
        end
        chk("bp_beats",   32'(accepted), 32'd4);
        chk("bp_release", 32'(gnt), 32'h00);

        // Early drop on channel 4 after two beats.
        req = 8'h10;
        wait_gnt("drop_gnt", 8'h10, 4);
        @(negedge clk);
        @(negedge clk);
        req = 8'h00;
        @(negedge clk);
        chk("drop_gnt_idle", 32'(gnt), 32'h00);
        chk("drop_ov",       32'(out_valid), 32'd0);
        req = 8'h11;
        @(negedge clk);
        chk("drop_next_gnt",  32'(gnt), 32'h01);
        chk("drop_next_ctrl", 32'(ctrl), 32'd0);

        // Everyone requesting from a fresh pointer.
        rst_n = 1'b0;
        req   = 8'hFF;
        @(negedge clk);
        rst_n = 1'b1;
        for (int g = 0; g < 9; g++) begin
            @(negedge clk);
            chk("all_gnt",  32'(gnt), 32'd1 << (g % 8));
            chk("all_ctrl", 32'(ctrl), 32'(g % 8));
            for (int b = 1; b < 4; b++) begin
                @(negedge clk);
                chk("all_hold", 32'(ctrl), 32'(g % 8));
            end
            @(negedge clk);
            chk("all_bubble", 32'(gnt), 32'h00);
        end

        // Randomized traffic; the model comparison runs every cycle.
        for (int cyc = 0; cyc < 4000; cyc++) begin
            @(negedge clk);
            if ($urandom_range(3) == 0) req = 8'($urandom);
            else if ($urandom_range(7) == 0) req = req ^ (8'h01 << $urandom_range(7));
            out_ready = ($urandom_range(3) != 0);
            if ($urandom_range(499) == 0) begin
                #2 rst_n = 1'b0;
                #2 rst_n = 1'b1;
            end
        end

        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
